// File: rtl/kianv_icache_dm_if.sv
// Request/response bundle between the MMU-side requester, the instruction cache and the memory bus.
// The cache takes the slave view; the environment (MMU plus bus) takes the master view.
interface kianv_icache_dm_if;
   logic        cpu_valid;
   logic        cpu_ready;
   logic [3:0]  cpu_wstrb;
   logic [33:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        is_instruction;
   logic        icache_flush;
   logic        cpu_access_fault;
   logic        mem_valid;
   logic        mem_ready;
   logic [3:0]  mem_wstrb;
   logic [33:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        access_fault;

   modport slave (
      input  cpu_valid, cpu_wstrb, cpu_addr, cpu_wdata, is_instruction, icache_flush,
             mem_ready, mem_rdata, access_fault,
      output cpu_ready, cpu_rdata, cpu_access_fault, mem_valid, mem_wstrb, mem_addr, mem_wdata
   );

   modport master (
      output cpu_valid, cpu_wstrb, cpu_addr, cpu_wdata, is_instruction, icache_flush,
             mem_ready, mem_rdata, access_fault,
      input  cpu_ready, cpu_rdata, cpu_access_fault, mem_valid, mem_wstrb, mem_addr, mem_wdata
   );
endinterface

// File: rtl/kianv_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache; non-cacheable traffic passes straight through.
// Fence.i flush and stores that hit a cached line invalidate it.
module kianv_icache_dm #(
   parameter int          NUM_LINES      = 64,
   parameter logic [33:0] CACHEABLE_BASE = 34'h0_8000_0000,
   parameter logic [33:0] CACHEABLE_END  = 34'h0_9000_0000
) (
   input logic              clk,
   input logic              reset,
   kianv_icache_dm_if.slave bus
);
   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = 32 - IDX_W;

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, PASS, RESP} state_t;
   state_t state_reg, state_next;

   logic [3:0]  wstrb_reg;
   logic [33:0] addr_reg;
   logic [31:0] wdata_reg;
   logic        instr_reg;
   logic [31:0] rdata_reg;
   logic        fault_reg;
   logic        no_alloc_reg;
   logic        mem_valid_reg;
   logic [3:0]  mem_wstrb_reg;
   logic [33:0] mem_addr_reg;
   logic [31:0] mem_wdata_reg;
   logic        valid_reg [NUM_LINES];

   logic [TAG_W-1:0] tag_mem [NUM_LINES];
   logic [31:0]      data_mem [NUM_LINES];
   logic [TAG_W-1:0] tag_q;
   logic [31:0]      data_q;

   logic [IDX_W-1:0] idx_in;
   logic [IDX_W-1:0] idx_reg;
   logic [TAG_W-1:0] tag_reg;
   logic             cacheable;
   logic             tag_match;
   logic             hit;
   logic             store_inval;
   logic             alloc;

   assign idx_in  = bus.cpu_addr[IDX_W+1:2];
   assign idx_reg = addr_reg[IDX_W+1:2];
   assign tag_reg = addr_reg[33:IDX_W+2];

   assign cacheable = instr_reg && (wstrb_reg == 4'h0) &&
                      (addr_reg >= CACHEABLE_BASE) && (addr_reg < CACHEABLE_END);
   // tag_q/data_q were read at the index latched in IDLE, so they line up with addr_reg here
   assign tag_match   = valid_reg[idx_reg] && (tag_q == tag_reg);
   assign hit         = cacheable && tag_match && !bus.icache_flush;
   assign store_inval = (state_reg == LOOKUP) && (wstrb_reg != 4'h0) && tag_match;
   assign alloc       = (state_reg == FILL) && bus.mem_ready && !bus.access_fault &&
                        !no_alloc_reg && !bus.icache_flush;

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:      if (bus.cpu_valid) state_next = LOOKUP;
         LOOKUP:    state_next = hit ? RESP : (cacheable ? FILL : PASS);
         FILL, PASS: if (bus.mem_ready) state_next = RESP;
         RESP:      state_next = IDLE;
         default:   state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (state_reg == IDLE && bus.cpu_valid) begin
         tag_q  <= tag_mem[idx_in];
         data_q <= data_mem[idx_in];
      end
      if (alloc) begin
         tag_mem[idx_reg]  <= tag_reg;
         data_mem[idx_reg] <= bus.mem_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wstrb_reg     <= '0;
         addr_reg      <= '0;
         wdata_reg     <= '0;
         instr_reg     <= 1'b0;
         rdata_reg     <= '0;
         fault_reg     <= 1'b0;
         no_alloc_reg  <= 1'b0;
         mem_valid_reg <= 1'b0;
         mem_wstrb_reg <= '0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (bus.cpu_valid) begin
                  wstrb_reg <= bus.cpu_wstrb;
                  addr_reg  <= bus.cpu_addr;
                  wdata_reg <= bus.cpu_wdata;
                  instr_reg <= bus.is_instruction;
               end
            end
            LOOKUP: begin
               if (hit) begin
                  rdata_reg <= data_q;
                  fault_reg <= 1'b0;
               end else begin
                  mem_valid_reg <= 1'b1;
                  mem_addr_reg  <= {addr_reg[33:2], 2'b00};
                  mem_wstrb_reg <= wstrb_reg;
                  mem_wdata_reg <= wdata_reg;
                  no_alloc_reg  <= 1'b0;
               end
            end
            FILL, PASS: begin
               // a flush seen mid-fill means the returning word may be stale after fence.i
               if (bus.icache_flush) no_alloc_reg <= 1'b1;
               if (bus.mem_ready) begin
                  mem_valid_reg <= 1'b0;
                  rdata_reg     <= bus.mem_rdata;
                  fault_reg     <= bus.access_fault;
               end
            end
            default: ;
         endcase
      end
   end

   // flush has priority over a same-edge allocate
   for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_valid
      always_ff @(posedge clk) begin
         if (reset || bus.icache_flush)
            valid_reg[gi] <= 1'b0;
         else if (alloc && idx_reg == IDX_W'(gi))
            valid_reg[gi] <= 1'b1;
         else if (store_inval && idx_reg == IDX_W'(gi))
            valid_reg[gi] <= 1'b0;
      end
   end

   assign bus.cpu_ready        = (state_reg == RESP);
   assign bus.cpu_rdata        = rdata_reg;
   assign bus.cpu_access_fault = (state_reg == RESP) && fault_reg;
   assign bus.mem_valid        = mem_valid_reg;
   assign bus.mem_wstrb        = mem_wstrb_reg;
   assign bus.mem_addr         = mem_addr_reg;
   assign bus.mem_wdata        = mem_wdata_reg;
endmodule
